// File: rtl/data_writer.sv
// data_writer: splits DATASIZE-bit packets into 32-bit buffer writes, then hands the buffer to the reader.
// Build option DATA_WRITER_BYTESWAP_EN: byte-reverse every written word (big-endian host words).
module data_writer #(
    parameter int DATASIZE    = 192,
    parameter int NUM_PACKETS = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATASIZE-1:0] pktIn,
    input  logic                pktValid,
    output logic                pktReady,
    input  logic                flush,
    input  logic                OutOfData,
    output logic [31:0]         addrB,
    output logic [31:0]         dataB,
    output logic                weB,
    output logic                DONE_WRITING,
    output logic [9:0]          pktCount
);

    localparam int WORDS = DATASIZE / 32;
    localparam int IW    = $clog2(WORDS + 1);

    localparam logic [IW-1:0] LASTW = IW'(WORDS);
    localparam logic [9:0]    NP    = 10'(NUM_PACKETS);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DONE,
        DRAIN_LO,
        DRAIN_HI
    } state_t;

    state_t              state;
    logic [DATASIZE-1:0] shiftReg;
    logic [29:0]         wordAddr;
    logic [IW-1:0]       wordIdx;
    logic                flushPend;
    logic                live;
    logic                accept;
    logic                room;
    logic                lastWord;
    logic [9:0]          nextCount;

    // Word presented on the write port, optionally byte-reversed.
    function automatic logic [31:0] word_out(input logic [31:0] w);
`ifdef DATA_WRITER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Handshake: only IDLE accepts, and only while the reader is idle and the fill has room.
    always_comb begin
        room      = (pktCount < NP);
        pktReady  = live && (state == IDLE) && OutOfData && !flushPend && room;
        accept    = pktValid && pktReady;
        lastWord  = (wordIdx == LASTW);
        nextCount = pktCount + 10'd1;
    end

    // Main FSM; write-port outputs are loaded one edge ahead so they are pure registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shiftReg     <= '0;
            wordAddr     <= '0;
            wordIdx      <= '0;
            flushPend    <= 1'b0;
            live         <= 1'b0;
            addrB        <= '0;
            dataB        <= '0;
            weB          <= 1'b0;
            DONE_WRITING <= 1'b0;
            pktCount     <= '0;
        end else begin
            live <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        weB       <= 1'b1;
                        addrB     <= {wordAddr, 2'b00};
                        dataB     <= word_out(pktIn[31:0]);
                        shiftReg  <= pktIn >> 32;
                        wordAddr  <= wordAddr + 30'd1;
                        wordIdx   <= IW'(1);
                        flushPend <= flush;
                        state     <= WRITE;
                    end else if (flush && (pktCount != 10'd0)) begin
                        DONE_WRITING <= 1'b1;
                        flushPend    <= 1'b0;
                        state        <= DONE;
                    end
                end
                WRITE: begin
                    flushPend <= flushPend | flush;
                    if (lastWord) begin
                        weB      <= 1'b0;
                        pktCount <= nextCount;
                        if (nextCount == NP || flushPend || flush) begin
                            DONE_WRITING <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        weB      <= 1'b1;
                        addrB    <= {wordAddr, 2'b00};
                        dataB    <= word_out(shiftReg[31:0]);
                        shiftReg <= shiftReg >> 32;
                        wordAddr <= wordAddr + 30'd1;
                        wordIdx  <= wordIdx + IW'(1);
                    end
                end
                DONE: begin
                    DONE_WRITING <= 1'b0;
                    flushPend    <= 1'b0;
                    state        <= DRAIN_LO;
                end
                DRAIN_LO: begin
                    if (!OutOfData) begin
                        state <= DRAIN_HI;
                    end
                end
                DRAIN_HI: begin
                    if (OutOfData) begin
                        wordAddr <= '0;
                        pktCount <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_writer.sv
// tb_data_writer: directed and randomized checks of data_writer against a write-queue reference model.
// Honours DATA_WRITER_BYTESWAP_EN when computing expected write data.
module tb_data_writer;

    localparam int DS    = 192;
    localparam int NP    = 3;
    localparam int WORDS = DS / 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [DS-1:0] pktIn;
    logic          pktValid;
    logic          pktReady;
    logic          flush;
    logic          OutOfData;
    logic [31:0]   addrB;
    logic [31:0]   dataB;
    logic          weB;
    logic          DONE_WRITING;
    logic [9:0]    pktCount;

    data_writer #(.DATASIZE(DS), .NUM_PACKETS(NP)) dut (
        .clock       (clock),
        .reset       (reset),
        .pktIn       (pktIn),
        .pktValid    (pktValid),
        .pktReady    (pktReady),
        .flush       (flush),
        .OutOfData   (OutOfData),
        .addrB       (addrB),
        .dataB       (dataB),
        .weB         (weB),
        .DONE_WRITING(DONE_WRITING),
        .pktCount    (pktCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exq[$];
    int  m_pkts   = 0;
    int  passed   = 0;
    int  total    = 0;
    int  cyc      = 0;
    int  nwr      = 0;
    int  ndone    = 0;
    int  exp_done = 0;

    function automatic logic [31:0] sw(input logic [31:0] w);
        logic [31:0] r;
`ifdef DATA_WRITER_BYTESWAP_EN
        r = {<<8{w}};
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: a packet in slot p of the fill yields WORDS writes at (p*WORDS+k)*4
    task automatic model_push(input logic [DS-1:0] p);
        for (int k = 0; k < WORDS; k++) begin
            wr_t e;
            e.a = 32'((m_pkts * WORDS + k) * 4);
            e.d = sw(p[32*k +: 32]);
            exq.push_back(e);
        end
        m_pkts++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (weB === 1'b1) begin
            nwr++;
            chk("wr_pending", 32'(exq.size() != 0), 32'd1);
            if (exq.size() != 0) begin
                wr_t e;
                e = exq.pop_front();
                chk("wr_addr", addrB, e.a);
                chk("wr_data", dataB, e.d);
            end
        end
        if (DONE_WRITING === 1'b1) ndone++;
    endtask

    function automatic logic [DS-1:0] rnd_pkt();
        logic [DS-1:0] p;
        for (int k = 0; k < WORDS; k++) p[32*k +: 32] = $urandom;
        return p;
    endfunction

    task automatic send(input logic [DS-1:0] p, output int acc);
        bit got;
        got      = 1'b0;
        acc      = -1;
        pktIn    = p;
        pktValid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pktReady === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                model_push(p);
                step();
                break;
            end
            step();
        end
        pktValid = 1'b0;
        chk("accept_seen", 32'(got), 32'd1);
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rdy", 32'(pktReady), 32'd0);
        end
        OutOfData = 1'b0;
        step();
        chk("drain_lo_rdy", 32'(pktReady), 32'd0);
        step();
        OutOfData = 1'b1;
        chk("drain_hi_rdy", 32'(pktReady), 32'd0);
        step();
        m_pkts = 0;
        chk("drained_rdy", 32'(pktReady), 32'd1);
        chk("drained_cnt", 32'(pktCount), 32'd0);
    endtask

    task automatic fill(input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(rnd_pkt(), a);
        end
        repeat (WORDS - 1) step();
        step();
        if (n == NP) begin
            chk("fill_done", 32'(DONE_WRITING), 32'd1);
        end else begin
            chk("fill_nodone", 32'(DONE_WRITING), 32'd0);
            flush = 1'b1;
            step();
            flush = 1'b0;
            chk("fill_flush_done", 32'(DONE_WRITING), 32'd1);
        end
        exp_done++;
        chk("fill_cnt", 32'(pktCount), 32'(n));
        drain($urandom_range(0, 2));
        chk("fill_q_empty", 32'(exq.size()), 32'd0);
        chk("fill_ndone", 32'(ndone), 32'(exp_done));
    endtask

    initial begin
        logic [DS-1:0] p;
        int a1, a2, w0;
        reset     = 1'b1;
        pktIn     = '0;
        pktValid  = 1'b0;
        flush     = 1'b0;
        OutOfData = 1'b1;
        repeat (2) step();
        chk("rst_rdy", 32'(pktReady), 32'd0);
        chk("rst_we", 32'(weB), 32'd0);
        chk("rst_done", 32'(DONE_WRITING), 32'd0);
        chk("rst_addr", addrB, 32'd0);
        chk("rst_data", dataB, 32'd0);
        chk("rst_cnt", 32'(pktCount), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_rdy", 32'(pktReady), 32'd0);
        step();
        chk("first_rdy", 32'(pktReady), 32'd1);

        // directed packet, six consecutive writes
        p = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        send(p, a1);
        chk("we_first", 32'(weB), 32'd1);
        repeat (WORDS - 1) begin
            step();
            chk("we_run", 32'(weB), 32'd1);
        end
        step();
        chk("we_end", 32'(weB), 32'd0);
        chk("no_done_1", 32'(DONE_WRITING), 32'd0);
        chk("cnt_1", 32'(pktCount), 32'd1);
        chk("rdy_idle", 32'(pktReady), 32'd1);

        // back-to-back with pktValid held completes the fill
        p = rnd_pkt();
        p[31:0] = 32'h11223344;
        send(p, a1);
        send(rnd_pkt(), a2);
        chk("b2b_gap", 32'(a2 - a1), 32'(WORDS + 1));
        repeat (WORDS - 1) step();
        chk("cnt_2", 32'(pktCount), 32'd2);
        chk("no_done_2", 32'(DONE_WRITING), 32'd0);
        step();
        chk("full_done", 32'(DONE_WRITING), 32'd1);
        chk("cnt_3", 32'(pktCount), 32'd3);
        chk("full_we", 32'(weB), 32'd0);
        exp_done++;
        step();
        chk("done_pulse", 32'(DONE_WRITING), 32'd0);
        drain(2);
        chk("ndone_a", 32'(ndone), 32'(exp_done));
        chk("q_empty_a", 32'(exq.size()), 32'd0);

        // flush on an empty buffer is dropped
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        chk("flush_empty", 32'(ndone), 32'(exp_done));
        chk("flush_empty_rdy", 32'(pktReady), 32'd1);

        // flush in IDLE after one packet
        send(rnd_pkt(), a1);
        repeat (WORDS - 1) step();
        step();
        chk("pre_flush", 32'(DONE_WRITING), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("idle_flush_done", 32'(DONE_WRITING), 32'd1);
        chk("idle_flush_cnt", 32'(pktCount), 32'd1);
        exp_done++;
        drain(0);

        // flush during WRITE waits for the packet to finish
        w0 = nwr;
        send(rnd_pkt(), a1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (WORDS - 2) step();
        chk("wflush_we", 32'(weB), 32'd1);
        chk("wflush_nodone", 32'(DONE_WRITING), 32'd0);
        step();
        chk("wflush_done", 32'(DONE_WRITING), 32'd1);
        chk("wflush_words", 32'(nwr - w0), 32'(WORDS));
        exp_done++;
        drain(1);

        // flush together with handshake: packet taken, then handover
        pktIn    = rnd_pkt();
        pktValid = 1'b1;
        flush    = 1'b1;
        chk("sim_rdy", 32'(pktReady), 32'd1);
        model_push(pktIn);
        step();
        pktValid = 1'b0;
        flush    = 1'b0;
        chk("restart_addr", addrB, 32'd0);
        repeat (WORDS - 1) step();
        step();
        chk("sim_done", 32'(DONE_WRITING), 32'd1);
        chk("sim_cnt", 32'(pktCount), 32'd1);
        exp_done++;
        drain(0);

        // reset during the third write of the second packet
        send(rnd_pkt(), a1);
        repeat (WORDS - 1) step();
        step();
        send(rnd_pkt(), a1);
        step();
        step();
        chk("pre_rst_we", 32'(weB), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(weB), 32'd0);
        chk("mid_rst_done", 32'(DONE_WRITING), 32'd0);
        chk("mid_rst_cnt", 32'(pktCount), 32'd0);
        chk("mid_rst_rdy", 32'(pktReady), 32'd0);
        exq.delete();
        m_pkts = 0;
        step();
        step();
        reset = 1'b0;
        step();
        send(rnd_pkt(), a1);
        chk("post_rst_addr", addrB, 32'd0);
        repeat (WORDS - 1) step();
        step();
        chk("post_rst_nodone", 32'(DONE_WRITING), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("post_rst_done", 32'(DONE_WRITING), 32'd1);
        exp_done++;
        drain(0);
        chk("ndone_b", 32'(ndone), 32'(exp_done));

        // randomized fills
        for (int f = 0; f < 6; f++) begin
            fill($urandom_range(1, NP));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
